pong_pixel_renderer: RTL and testbench

- Parametrised, pipelined pixel compositor for the pong display. It supersedes the fixed-size renderer.
- Draws border, two paddles, dashed net, ball, and two seven-segment score digits (0–9).
- Position and score inputs are latched once per frame, so the picture never tears.
- The winning player's digit blinks at a programmable frame rate.
- Sits between the VGA timing generator (pixel coordinates, frame pulse) and the VGA output driver.

---
 rtl/pong_pkg.sv | 48 ++++
 rtl/pong_pixel_renderer_seg_digit_hit.sv | 51 +++++
 rtl/pong_pixel_renderer.sv | 162 ++++++++++++++++
 tb/tb_pong_pixel_renderer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared colours, default pong geometry, hit-flag bundle and the seven-segment
// glyph table used by the pixel renderer and its neighbours.
package pong_pkg;

  localparam logic [23:0] WHITE  = 24'hFFFFFF;
  localparam logic [23:0] BLACK  = 24'h000000;
  localparam logic [23:0] RED    = 24'hFF0000;
  localparam logic [23:0] CYAN   = 24'h00FFFF;
  localparam logic [23:0] YELLOW = 24'hFFFF00;

  localparam int unsigned DEF_XW       = 10;
  localparam int unsigned DEF_H_DISP   = 640;
  localparam int unsigned DEF_V_DISP   = 480;
  localparam int unsigned DEF_BORDER   = 40;
  localparam int unsigned DEF_PAD_W    = 10;
  localparam int unsigned DEF_PAD_L    = 80;
  localparam int unsigned DEF_PAD0_X   = 60;
  localparam int unsigned DEF_PAD1_X   = 580;
  localparam int unsigned DEF_BALL_W   = 10;
  localparam int unsigned DEF_NET_HALF = 2;
  localparam int unsigned DEF_NET_LOG2 = 4;
  localparam int unsigned DEF_DIG_X0   = 280;
  localparam int unsigned DEF_DIG_X1   = 340;
  localparam int unsigned DEF_DIG_Y    = 50;
  localparam int unsigned DEF_DIG_W    = 20;
  localparam int unsigned DEF_DIG_H    = 40;
  localparam int unsigned DEF_STROKE   = 5;

  typedef struct packed {
    logic ball;
    logic dig;
    logic dig_yel;
    logic border;
    logic pad;
    logic net;
  } hits_t;

  // Bit 6 = segment a ... bit 0 = segment g.
  localparam logic [6:0] SEG_LUT [10] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
  };

  function automatic logic [6:0] seg_lut(input logic [3:0] d);
    return (d > 4'd9) ? SEG_LUT[9] : SEG_LUT[d];
  endfunction

endpackage

// File: rtl/pong_pixel_renderer_seg_digit_hit.sv
// Combinational seven-segment glyph hit test for one score digit box.
module seg_digit_hit
  import pong_pkg::*;
#(
  parameter int unsigned XW     = DEF_XW,
  parameter int unsigned DIG_W  = DEF_DIG_W,
  parameter int unsigned DIG_H  = DEF_DIG_H,
  parameter int unsigned STROKE = DEF_STROKE
)(
  input  logic [XW-1:0] x_i,
  input  logic [XW-1:0] y_i,
  input  logic [XW-1:0] ox_i,
  input  logic [XW-1:0] oy_i,
  input  logic [3:0]    digit_i,
  output logic          hit_o
);

  localparam int unsigned GY  = (DIG_H - STROKE) / 2;
  localparam int unsigned MID = GY + STROKE / 2;

  localparam logic [XW:0] C_W   = DIG_W[XW:0];
  localparam logic [XW:0] C_H   = DIG_H[XW:0];
  localparam logic [XW:0] C_ST  = STROKE[XW:0];
  localparam logic [XW:0] C_GY  = GY[XW:0];
  localparam logic [XW:0] C_MID = MID[XW:0];

  logic [XW:0] x, y, ox, oy;
  logic        in_box, seg_a, seg_d, seg_g, right, left, upper;
  logic [6:0]  segs;

  assign x  = {1'b0, x_i};
  assign y  = {1'b0, y_i};
  assign ox = {1'b0, ox_i};
  assign oy = {1'b0, oy_i};

  assign in_box = (x >= ox) && (x < ox + C_W) && (y >= oy) && (y < oy + C_H);
  assign seg_a  = y < oy + C_ST;
  assign seg_d  = y >= oy + C_H - C_ST;
  assign seg_g  = (y >= oy + C_GY) && (y < oy + C_GY + C_ST);
  assign right  = x >= ox + C_W - C_ST;
  assign left   = x < ox + C_ST;
  assign upper  = y < oy + C_MID;
  assign segs   = seg_lut(digit_i);

  assign hit_o = in_box &
                 ((segs[6] & seg_a) | (segs[5] & right & upper) |
                  (segs[4] & right & ~upper) | (segs[3] & seg_d) |
                  (segs[2] & left & ~upper) | (segs[1] & left & upper) |
                  (segs[0] & seg_g));

endmodule

// File: rtl/pong_pixel_renderer.sv
// Two-stage pong pixel compositor: frame-latched object state, layer hit
// flags in stage 1, priority colour mux in stage 2.
module pong_pixel_renderer
  import pong_pkg::*;
#(
  parameter int unsigned XW           = DEF_XW,
  parameter int unsigned H_DISP       = DEF_H_DISP,
  parameter int unsigned V_DISP       = DEF_V_DISP,
  parameter int unsigned BORDER       = DEF_BORDER,
  parameter int unsigned PAD_W        = DEF_PAD_W,
  parameter int unsigned PAD_L        = DEF_PAD_L,
  parameter int unsigned PAD0_X       = DEF_PAD0_X,
  parameter int unsigned PAD1_X       = DEF_PAD1_X,
  parameter int unsigned BALL_W       = DEF_BALL_W,
  parameter int unsigned NET_HALF     = DEF_NET_HALF,
  parameter int unsigned NET_LOG2     = DEF_NET_LOG2,
  parameter int unsigned DIG_X0       = DEF_DIG_X0,
  parameter int unsigned DIG_X1       = DEF_DIG_X1,
  parameter int unsigned DIG_Y        = DEF_DIG_Y,
  parameter int unsigned DIG_W        = DEF_DIG_W,
  parameter int unsigned DIG_H        = DEF_DIG_H,
  parameter int unsigned STROKE       = DEF_STROKE,
  parameter int unsigned BLINK_FRAMES = 30
)(
  input  logic          vga_clk,
  input  logic          sys_rst_n,
  input  logic [XW-1:0] pixel_xpos,
  input  logic [XW-1:0] pixel_ypos,
  input  logic          frame_start,
  input  logic [XW-1:0] pad0_y,
  input  logic [XW-1:0] pad1_y,
  input  logic [XW-1:0] ball_x,
  input  logic [XW-1:0] ball_y,
  input  logic [3:0]    score_l,
  input  logic [3:0]    score_r,
  input  logic [1:0]    winner,
  output logic [23:0]   pixel_data
);

  localparam int unsigned CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_FRAMES - 1);

  localparam int unsigned RX = H_DISP - BORDER;
  localparam int unsigned BY = V_DISP - BORDER;
  localparam int unsigned NL = H_DISP / 2 - NET_HALF;
  localparam int unsigned NR = H_DISP / 2 + NET_HALF;

  localparam logic [XW:0] C_BORDER = BORDER[XW:0];
  localparam logic [XW:0] C_RX     = RX[XW:0];
  localparam logic [XW:0] C_BY     = BY[XW:0];
  localparam logic [XW:0] C_NL     = NL[XW:0];
  localparam logic [XW:0] C_NR     = NR[XW:0];
  localparam logic [XW:0] C_PW     = PAD_W[XW:0];
  localparam logic [XW:0] C_PL     = PAD_L[XW:0];
  localparam logic [XW:0] C_P0X    = PAD0_X[XW:0];
  localparam logic [XW:0] C_P1X    = PAD1_X[XW:0];
  localparam logic [XW:0] C_BW     = BALL_W[XW:0];
  localparam logic [XW-1:0] C_DX0  = DIG_X0[XW-1:0];
  localparam logic [XW-1:0] C_DX1  = DIG_X1[XW-1:0];
  localparam logic [XW-1:0] C_DY   = DIG_Y[XW-1:0];

  logic [XW-1:0] pad0_q, pad1_q, ball_x_q, ball_y_q;
  logic [3:0]    score_l_q, score_r_q;
  logic [1:0]    winner_q;
  logic [CW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_on_q, blink_on_d;
  hits_t         hits_d, hits_q;
  logic [23:0]   pixel_d, pixel_q;

  logic [XW:0] x1, y1;
  logic        dig_l_hit, dig_r_hit, show_l, show_r;

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pad0_q      <= '0;
      pad1_q      <= '0;
      ball_x_q    <= '0;
      ball_y_q    <= '0;
      score_l_q   <= '0;
      score_r_q   <= '0;
      winner_q    <= '0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      hits_q      <= '0;
      pixel_q     <= '0;
    end else begin
      if (frame_start) begin
        pad0_q    <= pad0_y;
        pad1_q    <= pad1_y;
        ball_x_q  <= ball_x;
        ball_y_q  <= ball_y;
        score_l_q <= score_l;
        score_r_q <= score_r;
        winner_q  <= winner;
      end
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      hits_q      <= hits_d;
      pixel_q     <= pixel_d;
    end
  end

  // A fresh win restarts the blink phase visible; only latches that keep a
  // winner already in place advance the counter.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    if (frame_start) begin
      if (winner == 2'b00 || winner_q == 2'b00) begin
        blink_cnt_d = '0;
        blink_on_d  = 1'b1;
      end else if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + CW'(1);
      end
    end
  end

  assign x1 = {1'b0, pixel_xpos};
  assign y1 = {1'b0, pixel_ypos};

  seg_digit_hit #(.XW(XW), .DIG_W(DIG_W), .DIG_H(DIG_H), .STROKE(STROKE)) u_dig_l (
    .x_i(pixel_xpos), .y_i(pixel_ypos), .ox_i(C_DX0), .oy_i(C_DY),
    .digit_i(score_l_q), .hit_o(dig_l_hit)
  );

  seg_digit_hit #(.XW(XW), .DIG_W(DIG_W), .DIG_H(DIG_H), .STROKE(STROKE)) u_dig_r (
    .x_i(pixel_xpos), .y_i(pixel_ypos), .ox_i(C_DX1), .oy_i(C_DY),
    .digit_i(score_r_q), .hit_o(dig_r_hit)
  );

  assign show_l = dig_l_hit & ~(winner_q[1] & ~blink_on_q);
  assign show_r = dig_r_hit & ~(winner_q[0] & ~blink_on_q);

  always_comb begin
    hits_d         = '0;
    hits_d.ball    = (x1 >= {1'b0, ball_x_q}) && (x1 < {1'b0, ball_x_q} + C_BW) &&
                     (y1 >= {1'b0, ball_y_q}) && (y1 < {1'b0, ball_y_q} + C_BW);
    hits_d.dig     = show_l | show_r;
    hits_d.dig_yel = (show_l & winner_q[1]) | (show_r & winner_q[0]);
    hits_d.border  = (x1 < C_BORDER) || (x1 >= C_RX) || (y1 < C_BORDER) || (y1 >= C_BY);
    hits_d.pad     = ((x1 >= C_P0X) && (x1 < C_P0X + C_PW) &&
                      (y1 >= {1'b0, pad0_q}) && (y1 < {1'b0, pad0_q} + C_PL)) ||
                     ((x1 >= C_P1X) && (x1 < C_P1X + C_PW) &&
                      (y1 >= {1'b0, pad1_q}) && (y1 < {1'b0, pad1_q} + C_PL));
    hits_d.net     = (x1 >= C_NL) && (x1 < C_NR) && !pixel_ypos[NET_LOG2];
  end

  always_comb begin
    pixel_d = BLACK;
    if (hits_q.ball)        pixel_d = WHITE;
    else if (hits_q.dig)    pixel_d = hits_q.dig_yel ? YELLOW : WHITE;
    else if (hits_q.border) pixel_d = CYAN;
    else if (hits_q.pad)    pixel_d = WHITE;
    else if (hits_q.net)    pixel_d = RED;
  end

  assign pixel_data = pixel_q;

endmodule

// File: tb/tb_pong_pixel_renderer.sv
// Self-checking bench for pong_pixel_renderer: directed scenarios plus random
// frames checked against a geometric reference model.
module tb_pong_pixel_renderer;

  localparam int BF = 2;
  localparam int DW = 20, DH = 40, ST = 5;

  logic        vga_clk = 1'b0;
  logic        sys_rst_n;
  logic [9:0]  pixel_xpos, pixel_ypos, pad0_y, pad1_y, ball_x, ball_y;
  logic        frame_start;
  logic [3:0]  score_l, score_r;
  logic [1:0]  winner;
  logic [23:0] pixel_data;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: what the renderer should currently be showing.
  int m_pad0, m_pad1, m_bx, m_by, m_sl, m_sr, m_win, m_k;
  logic [23:0] expq[$];
  string       tagq[$];

  string GLYPH [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                        "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

  pong_pixel_renderer #(.BLINK_FRAMES(BF)) dut (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n),
    .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos), .frame_start(frame_start),
    .pad0_y(pad0_y), .pad1_y(pad1_y), .ball_x(ball_x), .ball_y(ball_y),
    .score_l(score_l), .score_r(score_r), .winner(winner),
    .pixel_data(pixel_data)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %06h expected %06h", tag, got, exp);
    end
  endtask

  function automatic bit in_rect(int x, int y, int rx, int ry, int w, int h);
    return x >= rx && x < rx + w && y >= ry && y < ry + h;
  endfunction

  function automatic bit dig_lit(int x, int y, int ox, int oy, int val);
    int lx = x - ox;
    int ly = y - oy;
    bit up;
    string s;
    if (lx < 0 || lx >= DW || ly < 0 || ly >= DH) return 0;
    if (val > 9) val = 9;
    s  = GLYPH[val];
    up = ly < (DH - ST) / 2 + ST / 2;
    for (int i = 0; i < s.len(); i++) begin
      case (s[i])
        "a": if (ly < ST) return 1;
        "d": if (ly >= DH - ST) return 1;
        "g": if (ly >= (DH - ST) / 2 && ly < (DH - ST) / 2 + ST) return 1;
        "b": if (lx >= DW - ST && up) return 1;
        "c": if (lx >= DW - ST && !up) return 1;
        "f": if (lx < ST && up) return 1;
        "e": if (lx < ST && !up) return 1;
        default: ;
      endcase
    end
    return 0;
  endfunction

  function automatic logic [23:0] model_px(int x, int y);
    bit on, sl, sr;
    on = (m_win == 0) || (((m_k / BF) % 2) == 0);
    sl = dig_lit(x, y, 280, 50, m_sl) && !(m_win[1] && !on);
    sr = dig_lit(x, y, 340, 50, m_sr) && !(m_win[0] && !on);
    if (in_rect(x, y, m_bx, m_by, 10, 10)) return 24'hFFFFFF;
    if (sl) return m_win[1] ? 24'hFFFF00 : 24'hFFFFFF;
    if (sr) return m_win[0] ? 24'hFFFF00 : 24'hFFFFFF;
    if (x < 40 || x >= 600 || y < 40 || y >= 440) return 24'h00FFFF;
    if (in_rect(x, y, 60, m_pad0, 10, 80) || in_rect(x, y, 580, m_pad1, 10, 80))
      return 24'hFFFFFF;
    if (x >= 318 && x < 322 && ((y / 16) % 2) == 0) return 24'hFF0000;
    return 24'h000000;
  endfunction

  task automatic model_latch();
    int w = int'(winner);
    if (w == 0 || m_win == 0) m_k = 0;
    else m_k++;
    m_pad0 = pad0_y; m_pad1 = pad1_y; m_bx = ball_x; m_by = ball_y;
    m_sl = score_l; m_sr = score_r; m_win = w;
  endtask

  task automatic model_reset();
    m_pad0 = 0; m_pad1 = 0; m_bx = 0; m_by = 0;
    m_sl = 0; m_sr = 0; m_win = 0; m_k = 0;
    expq.delete();
    tagq.delete();
  endtask

  // Apply one pixel (optionally with frame_start) and retire the pixel
  // applied two cycles earlier.
  task automatic cyc(input int x, input int y, input bit fs);
    pixel_xpos  = x[9:0];
    pixel_ypos  = y[9:0];
    frame_start = fs;
    expq.push_back(model_px(x, y));
    tagq.push_back($sformatf("px(%0d,%0d)", x, y));
    if (fs) model_latch();
    @(posedge vga_clk); #1;
    frame_start = 1'b0;
    if (expq.size() == 2) check(tagq.pop_front(), pixel_data, expq.pop_front());
  endtask

  task automatic drain();
    cyc(100, 300, 0);
    cyc(100, 300, 0);
  endtask

  task automatic do_reset(input string tag);
    sys_rst_n = 1'b0;
    #1;
    check({tag, "_async"}, pixel_data, 24'h000000);
    model_reset();
    @(posedge vga_clk); #1;
    check({tag, "_held"}, pixel_data, 24'h000000);
    sys_rst_n = 1'b1;
  endtask

  initial begin
    sys_rst_n = 1'b0;
    pixel_xpos = '0; pixel_ypos = '0; frame_start = 1'b0;
    pad0_y = '0; pad1_y = '0; ball_x = '0; ball_y = '0;
    score_l = '0; score_r = '0; winner = '0;
    model_reset();
    #1;
    check("reset_out", pixel_data, 24'h000000);
    repeat (2) @(posedge vga_clk);
    #1;
    check("reset_held", pixel_data, 24'h000000);
    sys_rst_n = 1'b1;

    cyc(0, 0, 0);
    cyc(0, 0, 0);
    drain();

    pad0_y = 10'd200; pad1_y = 10'd200;
    ball_x = 10'd300; ball_y = 10'd200;
    cyc(100, 300, 1);
    cyc(305, 205, 0);
    cyc(315, 205, 0);
    drain();

    score_l = 4'd1;
    cyc(100, 300, 1);
    cyc(297, 60, 0);
    cyc(282, 60, 0);
    score_l = 4'd8;
    cyc(100, 300, 1);
    cyc(290, 69, 0);
    score_l = 4'd12;
    cyc(100, 300, 1);
    cyc(282, 80, 0);
    cyc(282, 60, 0);
    drain();

    ball_x = 10'd400;
    cyc(305, 205, 0);
    cyc(305, 205, 0);
    cyc(100, 300, 1);
    cyc(305, 205, 0);
    drain();

    winner = 2'b10; score_l = 4'd3;
    for (int f = 1; f <= 5; f++) begin
      cyc(100, 300, 1);
      cyc(297, 60, 0);
      cyc(297, 60, 0);
    end
    winner = 2'b00;
    cyc(100, 300, 1);
    cyc(297, 60, 0);
    drain();

    pad0_y = 10'd20;
    cyc(100, 300, 1);
    cyc(65, 30, 0);
    cyc(65, 60, 0);
    cyc(320, 16, 0);
    cyc(320, 64, 0);
    cyc(320, 60, 0);
    cyc(700, 200, 0);
    drain();

    for (int i = 0; i < 1500; i++) begin
      int x, y;
      bit fs;
      if (i == 700) begin
        do_reset("midreset");
      end
      fs = ($urandom_range(0, 39) == 0);
      if (fs) begin
        pad0_y  = 10'($urandom_range(0, 1023));
        pad1_y  = 10'($urandom_range(0, 460));
        ball_x  = 10'($urandom_range(0, 1023));
        ball_y  = 10'($urandom_range(0, 1023));
        score_l = 4'($urandom_range(0, 15));
        score_r = 4'($urandom_range(0, 15));
        winner  = 2'($urandom_range(0, 3));
      end else if ($urandom_range(0, 7) == 0) begin
        ball_x = 10'($urandom_range(0, 1023));
        winner = 2'($urandom_range(0, 3));
      end
      case ($urandom_range(0, 3))
        0: begin x = $urandom_range(275, 365); y = $urandom_range(45, 95); end
        1: begin x = m_bx + $urandom_range(0, 14) - 2; y = m_by + $urandom_range(0, 14) - 2; end
        default: begin x = $urandom_range(0, 1023); y = $urandom_range(0, 1023); end
      endcase
      if (x < 0) x = 0;
      if (y < 0) y = 0;
      if (x > 1023) x = 1023;
      if (y > 1023) y = 1023;
      cyc(x, y, fs);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
